// File: rtl/rc_control_voltage.sv
// rc_control_voltage: RC charge/discharge envelope that drives a 555 VCO control input.
// A rising trigger charges v_control toward V_HIGH. A falling trigger discharges it
// toward V_REST, after which the block returns to idle. Each audio_clk_en strobe
// launches one exponential step through a 2-stage pipeline, so the result lands
// 2 clks after the strobe.
// Ports:
//   clk          - system clock
//   I_RST        - synchronous active-high reset
//   audio_clk_en - one-clk sample strobe (ignored while an update is in flight)
//   trigger      - sound-enable latch bit, synchronous to clk
//   v_control    - registered control voltage, always within [V_REST, V_HIGH]
//   active       - high whenever the state machine is not idle
module rc_control_voltage #(
  parameter int V_HIGH                     = 16384,
  parameter int V_REST                     = 0,
  parameter int ALPHA_CHARGE_16_SHIFTED    = 1311,
  parameter int ALPHA_DISCHARGE_16_SHIFTED = 328,
  parameter int SETTLE_TOL                 = 4
) (
  input  logic               clk,
  input  logic               I_RST,
  input  logic               audio_clk_en,
  input  logic               trigger,
  output logic signed [15:0] v_control,
  output logic               active
);

  localparam int unsigned VW = 16;  // output voltage width
  localparam int unsigned DW = 17;  // signed difference width
  localparam int unsigned AW = 16;  // alpha width (Q0.16)
  localparam int unsigned PW = 34;  // signed product width
  localparam int unsigned SW = 18;  // step / sum width, holds v + step without overflow

  localparam logic signed [SW-1:0] HI_S  = SW'(V_HIGH);
  localparam logic signed [SW-1:0] LO_S  = SW'(V_REST);
  localparam logic signed [SW-1:0] TOL_S = SW'(SETTLE_TOL);
  localparam logic signed [DW-1:0] HI_D  = DW'(V_HIGH);
  localparam logic signed [DW-1:0] LO_D  = DW'(V_REST);
  localparam logic [AW-1:0]        A_CHG = AW'(ALPHA_CHARGE_16_SHIFTED);
  localparam logic [AW-1:0]        A_DIS = AW'(ALPHA_DISCHARGE_16_SHIFTED);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHARGE    = 2'd1,
    DISCHARGE = 2'd2
  } state_t;

  state_t                state_q,    state_d;
  logic                  trig_q,     trig_d;
  logic signed [VW-1:0]  v_q,        v_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic signed [DW-1:0]  diff_q,     diff_d;
  logic [AW-1:0]         alpha_q,    alpha_d;
  logic signed [SW-1:0]  step_q,     step_d;
  logic                  wr_q,       wr_d;

  logic                  rise_c, fall_c, accept_c, settle_c;
  logic signed [DW-1:0]  target_c;
  logic signed [SW-1:0]  shifted_c, sum_c, clamp_c, dist_c;

  // Datapath: target select, scaled step, clamped sum and settle distance.
  always_comb begin
    target_c  = (state_q == CHARGE) ? HI_D : LO_D;
    // diff * alpha with alpha treated as unsigned; arithmetic shift floors the result
    shifted_c = SW'((PW'(diff_q) * PW'($signed({1'b0, alpha_q}))) >>> 16);
    sum_c     = SW'(v_q) + step_q;
    if (sum_c > HI_S) begin
      clamp_c = HI_S;
    end else if (sum_c < LO_S) begin
      clamp_c = LO_S;
    end else begin
      clamp_c = sum_c;
    end
    dist_c    = clamp_c - LO_S;
  end

  // Next-state: trigger edges, pipeline stages, write-back and FSM.
  always_comb begin
    state_d    = state_q;
    trig_d     = trigger;
    v_d        = v_q;
    s1_valid_d = 1'b0;
    s2_valid_d = s1_valid_q;
    diff_d     = diff_q;
    alpha_d    = alpha_q;
    step_d     = step_q;
    wr_d       = wr_q;
    settle_c   = 1'b0;

    rise_c   = trigger & ~trig_q;
    fall_c   = ~trigger & trig_q;
    // strobes that arrive mid-update are dropped, not queued
    accept_c = audio_clk_en & ~s1_valid_q & ~s2_valid_q;

    // Stage 1: uses the pre-transition state, so a same-cycle edge affects the next strobe
    if (accept_c) begin
      s1_valid_d = 1'b1;
      diff_d     = target_c - DW'(v_q);
      alpha_d    = (state_q == CHARGE) ? A_CHG : A_DIS;
    end

    // Stage 2: a zero step with nonzero diff is forced to +/-1 so the curve always converges
    if (s1_valid_q) begin
      wr_d = (diff_q != '0);
      if ((shifted_c == '0) && (diff_q != '0)) begin
        step_d = diff_q[DW-1] ? {SW{1'b1}} : SW'(1);
      end else begin
        step_d = shifted_c;
      end
    end

    // Write-back; discharge snaps to rest once within tolerance
    if (s2_valid_q && wr_q) begin
      v_d = VW'(clamp_c);
      if ((state_q == DISCHARGE) && (dist_c <= TOL_S)) begin
        v_d      = VW'(V_REST);
        settle_c = 1'b1;
      end
    end

    if (rise_c) begin
      state_d = CHARGE;
    end else if (fall_c && (state_q == CHARGE)) begin
      state_d = DISCHARGE;
    end else if (settle_c) begin
      state_d = IDLE;
    end
  end

  // State register with synchronous reset; reset also abandons any in-flight update.
  always_ff @(posedge clk) begin
    if (I_RST) begin
      state_q    <= IDLE;
      trig_q     <= 1'b0;
      v_q        <= VW'(V_REST);
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      alpha_q    <= '0;
      step_q     <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      v_q        <= v_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      alpha_q    <= alpha_d;
      step_q     <= step_d;
      wr_q       <= wr_d;
    end
  end

  assign v_control = v_q;
  assign active    = (state_q != IDLE);

endmodule
